// File: rtl/kb_uart_formatter_pkg.sv
// kb_fmt_pkg: shared FSM state type and ASCII constants for the scan-code formatter
package kb_fmt_pkg;

    typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF} fmt_state_t;

    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_A    = 8'h41;

endpackage

// File: rtl/kb_uart_formatter_nibble_to_ascii.sv
// nibble_to_ascii: maps a 4-bit value to its uppercase ASCII hex digit
module nibble_to_ascii
    import kb_fmt_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    assign asc = (nib < 4'd10) ? ASC_ZERO + {4'd0, nib} : ASC_A + {4'd0, nib} - 8'd10;

endmodule

// File: rtl/kb_uart_formatter.sv
// kb_uart_formatter: turns scan codes into "HH " hex text (CR LF after a break-prefixed byte); optional KB_FMT_DROP_CNT_EN adds a saturating drop counter
module kb_uart_formatter
    import kb_fmt_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter logic [7:0] BREAK_CODE = 8'hF0
`ifdef KB_FMT_DROP_CNT_EN
    ,
    parameter int DCNT_W = 8
`endif
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_done_tick,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       overflow
`ifdef KB_FMT_DROP_CNT_EN
    ,
    output logic [DCNT_W-1:0] drop_cnt
`endif
);

    fmt_state_t state, state_nxt;
    logic [7:0] cur, hold;
    logic       hold_vld, brk_armed;
    logic [3:0] nib;
    logic [7:0] nib_asc;
    logic       drop;

    assign nib  = (state == HI) ? cur[7:4] : cur[3:0];
    assign busy = (state != IDLE) || hold_vld;
    assign drop = (state != IDLE) && scan_done_tick && hold_vld;

    nibble_to_ascii u_n2a (
        .nib(nib),
        .asc(nib_asc)
    );

    // character selection, write strobe and next state; emitting states advance only on a write
    always_comb begin
        wr_uart   = (state != IDLE) && !tx_full;
        w_data    = 8'h00;
        state_nxt = state;
        case (state)
            IDLE: state_nxt = (scan_done_tick || hold_vld) ? HI : IDLE;
            HI: begin
                w_data    = nib_asc;
                state_nxt = wr_uart ? LO : HI;
            end
            LO: begin
                w_data    = nib_asc;
                state_nxt = wr_uart ? (brk_armed ? CR : SEP) : LO;
            end
            SEP: begin
                w_data    = SEP_CHAR;
                state_nxt = wr_uart ? IDLE : SEP;
            end
            CR: begin
                w_data    = ASC_CR;
                state_nxt = wr_uart ? LF : CR;
            end
            LF: begin
                w_data    = ASC_LF;
                state_nxt = wr_uart ? IDLE : LF;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end

    // current/hold byte queue, break arming and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= 8'h00;
            hold      <= 8'h00;
            hold_vld  <= 1'b0;
            brk_armed <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (scan_done_tick) begin
                    cur  <= hold_vld ? hold : scan_code;
                    hold <= scan_code;
                end else if (hold_vld) begin
                    cur      <= hold;
                    hold_vld <= 1'b0;
                end
            end else if (scan_done_tick) begin
                if (!hold_vld) begin
                    hold     <= scan_code;
                    hold_vld <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (wr_uart && (state == SEP || state == LF))
                brk_armed <= (cur == BREAK_CODE);
        end
    end

`ifdef KB_FMT_DROP_CNT_EN
    // saturating count of dropped scan codes
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= '0;
        else if (drop && !(&drop_cnt))
            drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule
